// File: rtl/ubs_pkg.sv
// Shared types and helpers for the unipolar-bitstream window counter family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   ubs_win_state_t : control state of a window counter (IDLE / RUN)
//   win_len()       : window length in valid bits for a given log2 width
package ubs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ubs_win_state_t;

  // Number of valid input bits in one window of 2^width bits.
  function automatic int unsigned win_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/ubs_win_cnt.sv
// Bit/ones counter pair for one 2^WIDTH-bit stochastic window.
// Latency: last/total are combinational on the current input bit.
// Backpressure: none; the counters advance on every enabled cycle.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clears both counters at the next edge (wins over en)
//   en         : counts the current bit
//   in         : stochastic bit counted when en=1
//   last       : en=1 and this bit closes the window
//   total      : ones counted so far including the current bit
module ubs_win_cnt
  import ubs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  output logic             last,
  output logic [WIDTH:0]   total
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(win_len(WIDTH) - 1);

  logic [WIDTH-1:0] bit_cnt;
  logic [WIDTH:0]   ones_cnt;

  assign last  = en && (bit_cnt == LAST_IDX);
  // ones_cnt never exceeds 2^WIDTH-1 before the last bit, so the sum fits.
  assign total = ones_cnt + {{WIDTH{1'b0}}, in};

  // The window-closing bit also wraps the counters so the next window
  // starts from zero without an extra clear cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (clr || last) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (en) begin
      bit_cnt  <= bit_cnt + WIDTH'(1);
      ones_cnt <= total;
    end
  end

endmodule

// File: rtl/ubs_win_counter.sv
// Stochastic-to-binary converter: counts 1s over windows of 2^WIDTH valid bits.
// Latency: result valid 1 cycle after the window's last bit is sampled.
// Backpressure: single output register; an unconsumed result is overwritten and flags sticky overrun.
//
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   start               : pulse; clears counters and begins a window
//   in_valid, in        : qualified stochastic input bit
//   out_data, out_valid : last completed window count (0..2^WIDTH), valid/ready
//   out_ready           : consumer accepts out_data when out_valid=1
//   busy                : high while a window is being counted
//   overrun, clr_ovr    : sticky overwrite flag and its synchronous clear
module ubs_win_counter
  import ubs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  ubs_win_state_t state;
  ubs_win_state_t state_nxt;

  logic           cnt_en;
  logic           last_bit;
  logic [WIDTH:0] win_total;
  logic           publish;
  logic           ovr_set;

  // Bits only count while running; start clears in either state, which
  // also discards the bit presented alongside a restart.
  assign cnt_en = (state == RUN) && in_valid;

  ubs_win_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (cnt_en),
    .in    (in),
    .last  (last_bit),
    .total (win_total)
  );

  // A window-closing bit always publishes, even when start arrives with it.
  assign publish = last_bit;
  assign ovr_set = publish && out_valid && !out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A start coinciding with the last bit keeps us in RUN
  // for a fresh window regardless of CONTINUOUS.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit && !start && !CONTINUOUS) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: busy comes straight from the state flop.
  always_comb begin
    busy = (state == RUN);
  end

  // Result register. A new result loads even if the previous one is still
  // pending; whether that counts as an overrun depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (publish) begin
      out_data  <= win_total;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun: a same-cycle set beats clr_ovr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule
